mult_seq_controller: RTL and testbench
======================================

Name: mult_seq_controller

Overview:
- Control unit for the repeated-addition multiplier datapath (registers R1, R2, R3, R4, R), sequenced by the one-hot enables Enable3, Enable7, Enable9 and Enable10.
- Accepts a start command and reads R1/R2 status straight from the datapath outputs. Steps the ASM load → optional operand swap → accumulate loop → result commit, then returns to idle.
- Adds an abort request, an iteration watchdog and busy/done/error status for the surrounding top level.

Parameters:
- WIDTH, 32, width of the R1/R2 status inputs; matches the datapath register width.
- CNT_W, 32, width of the iteration counter.
- MAX_ITER, 32'hFFFF_FFFF, watchdog limit on accumulate iterations; reaching it aborts the loop with error.
- SWAP_EN, 1, 1 = swap the operands when R1 > R2 so the loop runs over the smaller operand; 0 = never swap.

Ports:
- clk  input  1  rising-edge clock, shared with the datapath.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level; sampled only in IDLE.
- abort  input  1  synchronous; cancels an operation in progress.
- R1  input  WIDTH  datapath R1 (loop counter operand).
- R2  input  WIDTH  datapath R2 (addend operand).
- Enable3  output  1  load enable: R1=in1, R2=in2, R3=0, R=0.
- Enable7  output  1  operand swap enable.
- Enable9  output  1  commit enable: R4=R3, R=1.
- Enable10  output  1  accumulate enable: R3+=R2, R1-=1.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse, coincident with Enable9.
- error  output  1  sticky watchdog flag; cleared by the next accepted start.
- iter_count  output  CNT_W  number of Enable10 cycles issued in the current or last operation.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - All enables, done and error = 0; iter_count = 0.
  - Reset asserted mid-operation kills the operation immediately; no enable is asserted after reset.
- States: IDLE, LOAD, CMP, SWAP, LOOP, FINISH.
- Output decoding:
  - Enable3, Enable7 and Enable9 are Moore outputs of LOAD, SWAP and FINISH respectively.
  - Enable10 is Mealy: asserted only in LOOP && R1 != 0 && iter_count < MAX_ITER && !abort.
  - At most one enable is high in any cycle.
- IDLE:
  - start=1 → LOAD; iter_count and error cleared on the same edge.
  - start held high across completion re-launches one cycle after FINISH.
- LOAD: Enable3=1 for one cycle → CMP. R1/R2 are valid from CMP onward.
- CMP (no enable asserted):
  - SWAP_EN && R1 > R2 (unsigned) → SWAP.
  - Otherwise → LOOP.
- SWAP: Enable7=1 for one cycle → LOOP. The controller does not re-compare after the swap.
- LOOP:
  - R1 == 0 → FINISH, Enable10 = 0.
  - R1 != 0 and iter_count == MAX_ITER → error=1 → FINISH, Enable10 = 0.
  - Otherwise Enable10=1, iter_count+1, remain in LOOP.
- FINISH: Enable9=1 and done=1 for one cycle → IDLE. A watchdog exit still commits, so R4 holds the partial product.
- abort=1 in any state except IDLE → IDLE on the next edge with all enables 0 in that cycle; no Enable9, no done; error unchanged.
- Latency, start sampled to return to IDLE:
  - without swap: N+4 cycles (LOAD 1, CMP 1, LOOP N+1, FINISH 1), where N = R1 after load;
  - with swap: one extra cycle, with N = min(in1, in2).
- iter_count holds its value in IDLE until the next start.
- Unsigned compare and count; no wrap, since the count saturates at MAX_ITER.

Test Plan:
- Reset, then start with bench datapath model in1=3, in2=5 → Enable3 at cycle 1, no Enable7, Enable10 in cycles 3-5, Enable9+done at cycle 7; iter_count=3; R4=15.
- SWAP_EN=1, in1=7, in2=2 → Enable7 exactly once at cycle 3, Enable10 ×2, done; R4=14; iter_count=2.
- in1=0, in2=9 → LOOP exits immediately with no Enable10, Enable9 one cycle later; R4=0; iter_count=0.
- MAX_ITER=4, in1=10, in2=1 → Enable10 ×4, error=1, Enable9 asserted, R4=4; error clears on the next start.
- abort=1 during the 2nd Enable10 with in1=5 → IDLE next cycle; no Enable9, no done; busy falls.
- rst_n pulsed low mid-LOOP → all outputs 0 asynchronously. Separately, start pulsed while busy → ignored, with the same enable trace as a single start.

Source files
------------

// File: rtl/mult_seq_controller.sv
// ---------------------------------------------------------------------------
// mult_seq_controller
//
// Control unit for a repeated-addition multiplier datapath (R1, R2, R3, R4, R).
// It loads the operands, optionally swaps them so the loop runs over the
// smaller one, then accumulates R3 += R2 while counting R1 down to zero, and
// finally commits R3 into R4. An abort input, an iteration watchdog and
// busy/done/error status are provided for the surrounding top level.
//
// Ports:
//   clk        - rising-edge clock, shared with the datapath
//   rst_n      - asynchronous active-low reset
//   start      - level request, only sampled while idle
//   abort      - cancels an operation in progress (synchronous)
//   R1         - datapath R1, loop counter operand
//   R2         - datapath R2, addend operand
//   Enable3    - load:       R1=in1, R2=in2, R3=0, R=0
//   Enable7    - swap R1 and R2
//   Enable9    - commit:     R4=R3, R=1
//   Enable10   - accumulate: R3+=R2, R1-=1
//   busy       - high whenever the controller is not idle
//   done       - one-cycle pulse together with Enable9
//   error      - sticky watchdog flag, cleared by the next accepted start
//   iter_count - number of Enable10 cycles in the current or last operation
// ---------------------------------------------------------------------------
module mult_seq_controller #(
  parameter int               WIDTH    = 32,
  parameter int               CNT_W    = 32,
  parameter logic [CNT_W-1:0] MAX_ITER = 32'hFFFF_FFFF,
  parameter bit               SWAP_EN  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] R1,
  input  logic [WIDTH-1:0] R2,
  output logic             Enable3,
  output logic             Enable7,
  output logic             Enable9,
  output logic             Enable10,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] iter_count
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CMP,
    SWAP,
    LOOP,
    FINISH
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [CNT_W-1:0] r_iterCount;
  logic             r_error;

  logic w_r1Zero;
  logic w_atLimit;
  logic w_accumulate;

  // Loop status derived from the live datapath R1 and the iteration counter.
  // The counter never passes MAX_ITER, so reaching it is the watchdog trip.
  assign w_r1Zero     = (R1 == '0);
  assign w_atLimit    = (r_iterCount >= MAX_ITER);
  assign w_accumulate = (r_state == LOOP) && !w_r1Zero && !w_atLimit && !abort;

  // Main sequencer. Abort takes priority over every state except IDLE and
  // leaves the error flag untouched, so no commit happens on that path.
  // The iteration counter advances exactly when Enable10 is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_iterCount <= '0;
      r_error     <= 1'b0;
    end else if (abort && (r_state != IDLE)) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state     <= LOAD;
            r_iterCount <= '0;
            r_error     <= 1'b0;
          end
        end
        LOAD: begin
          r_state <= CMP;
        end
        CMP: begin
          if (SWAP_EN && (R1 > R2)) begin
            r_state <= SWAP;
          end else begin
            r_state <= LOOP;
          end
        end
        SWAP: begin
          r_state <= LOOP;
        end
        LOOP: begin
          if (w_r1Zero) begin
            r_state <= FINISH;
          end else if (w_atLimit) begin
            r_error <= 1'b1;
            r_state <= FINISH;
          end else begin
            r_iterCount <= r_iterCount + CNT_ONE;
          end
        end
        FINISH: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Enables decode straight from the state register; abort masks them in the
  // same cycle so a cancelled operation never touches the datapath again.
  assign Enable3    = (r_state == LOAD)   && !abort;
  assign Enable7    = (r_state == SWAP)   && !abort;
  assign Enable9    = (r_state == FINISH) && !abort;
  assign Enable10   = w_accumulate;
  assign done       = Enable9;
  assign busy       = (r_state != IDLE);
  assign error      = r_error;
  assign iter_count = r_iterCount;

endmodule

// File: tb/tb_mult_seq_controller.sv
// ---------------------------------------------------------------------------
// tb_mult_seq_controller
//
// Two controller instances each drive a behavioural datapath model:
//   instance 0 : default watchdog, swap enabled
//   instance 1 : watchdog limit 4, swap disabled
// Expected results are pushed to a scoreboard when an operation is launched
// and popped when the controller pulses done.
// ---------------------------------------------------------------------------
module tb_mult_seq_controller;

  typedef struct {
    int          sel;
    logic [31:0] product;
    logic [31:0] iter;
    logic [31:0] first10;
    logic [31:0] n10;
    logic [31:0] n7;
    logic [31:0] doneCyc;
    logic        err;
  } expRec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        abort;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [1:0]  startV;
  logic [1:0]  en3, en7, en9, en10, doneV, busyV, errV;
  logic [31:0] iterCnt [2];
  logic [31:0] dpR1 [2];
  logic [31:0] dpR2 [2];
  logic [31:0] dpR3 [2];
  logic [31:0] dpR4 [2];

  expRec_t     sbQ [$];
  int          numChecks = 0;
  int          numPass   = 0;

  bit          active [2];
  int          cyc [2];
  logic [31:0] m10 [2];
  logic [31:0] m7 [2];
  logic [31:0] mFirst10 [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gDut
    mult_seq_controller #(
      .WIDTH   (32),
      .CNT_W   (32),
      .MAX_ITER((g == 0) ? 32'hFFFF_FFFF : 32'd4),
      .SWAP_EN ((g == 0) ? 1'b1 : 1'b0)
    ) uDut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (startV[g]),
      .abort     (abort),
      .R1        (dpR1[g]),
      .R2        (dpR2[g]),
      .Enable3   (en3[g]),
      .Enable7   (en7[g]),
      .Enable9   (en9[g]),
      .Enable10  (en10[g]),
      .busy      (busyV[g]),
      .done      (doneV[g]),
      .error     (errV[g]),
      .iter_count(iterCnt[g])
    );
  end

  // Behavioural repeated-addition datapath driven by the controller enables.
  always @(posedge clk or negedge rst_n) begin
    for (int s = 0; s < 2; s++) begin
      if (!rst_n) begin
        dpR1[s] <= '0;
        dpR2[s] <= '0;
        dpR3[s] <= '0;
        dpR4[s] <= '0;
      end else if (en3[s]) begin
        dpR1[s] <= in1;
        dpR2[s] <= in2;
        dpR3[s] <= '0;
      end else if (en7[s]) begin
        dpR1[s] <= dpR2[s];
        dpR2[s] <= dpR1[s];
      end else if (en9[s]) begin
        dpR4[s] <= dpR3[s];
      end else if (en10[s]) begin
        dpR3[s] <= dpR3[s] + dpR2[s];
        dpR1[s] <= dpR1[s] - 32'd1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numChecks++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, observed, expected, $time);
    end else begin
      numPass++;
    end
  endtask

  // Reference outcome of one operation for the given instance configuration.
  function automatic expRec_t model(input int sel, input logic [31:0] a, input logic [31:0] b);
    expRec_t     r;
    logic        sw;
    logic [31:0] n, add, lim;
    lim       = (sel == 0) ? 32'hFFFF_FFFF : 32'd4;
    sw        = (sel == 0) && (a > b);
    n         = sw ? b : a;
    add       = sw ? a : b;
    r.sel     = sel;
    r.err     = (n > lim);
    r.iter    = r.err ? lim : n;
    r.product = r.iter * add;
    r.n10     = r.iter;
    r.n7      = 32'(sw);
    r.first10 = (r.iter != 0) ? 32'd3 + 32'(sw) : 32'd0;
    r.doneCyc = r.iter + 32'd4 + 32'(sw);
    return r;
  endfunction

  // Per-cycle monitor: enable exclusivity, trace bookkeeping and scoreboard
  // comparison on every done pulse. Cycle 0 is the idle cycle in which start
  // is seen.
  always @(negedge clk) begin
    expRec_t rec;
    int      hot;
    for (int s = 0; s < 2; s++) begin
      hot = 32'(en3[s]) + 32'(en7[s]) + 32'(en9[s]) + 32'(en10[s]);
      if (hot > 1) checkOutput("oneHot", 32'(hot), 32'd1);
      if (rst_n && !busyV[s] && startV[s]) begin
        active[s]   = 1'b1;
        cyc[s]      = 0;
        m10[s]      = '0;
        m7[s]       = '0;
        mFirst10[s] = '0;
      end else if (active[s]) begin
        cyc[s]++;
        if (cyc[s] == 1) begin
          checkOutput("en3Cycle1", 32'(en3[s]), 32'd1);
          checkOutput("errCleared", 32'(errV[s]), 32'd0);
        end
        if (en7[s]) m7[s] = m7[s] + 32'd1;
        if (en10[s]) begin
          if (m10[s] == 0) mFirst10[s] = 32'(cyc[s]);
          m10[s] = m10[s] + 32'd1;
        end
        if (doneV[s]) begin
          checkOutput("doneExpected", 32'(sbQ.size() > 0), 32'd1);
          if (sbQ.size() > 0) begin
            rec = sbQ.pop_front();
            checkOutput("instance", 32'(s), 32'(rec.sel));
            checkOutput("doneCycle", 32'(cyc[s]), rec.doneCyc);
            checkOutput("en9WithDone", 32'(en9[s]), 32'd1);
            checkOutput("en10Count", m10[s], rec.n10);
            checkOutput("en10First", mFirst10[s], rec.first10);
            checkOutput("en7Count", m7[s], rec.n7);
            checkOutput("iterCount", iterCnt[s], rec.iter);
            checkOutput("errorFlag", 32'(errV[s]), 32'(rec.err));
            checkOutput("product", dpR3[s], rec.product);
          end
          active[s] = 1'b0;
        end else if (!busyV[s]) begin
          active[s] = 1'b0;
        end
      end
    end
  end

  task automatic applyStimulus(input int sel, input logic [31:0] a, input logic [31:0] b,
                               input bit doPush);
    @(posedge clk);
    #1;
    if (doPush) sbQ.push_back(model(sel, a, b));
    in1         = a;
    in2         = b;
    startV[sel] = 1'b1;
    @(posedge clk);
    #1;
    startV[sel] = 1'b0;
  endtask

  task automatic waitIdle(input int sel, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busyV[sel] && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    if (busyV[sel]) checkOutput("idleTimeout", 32'(busyV[sel]), 32'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    int          n;
    rst_n  = 1'b0;
    abort  = 1'b0;
    startV = 2'b00;
    in1    = '0;
    in2    = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstOutputs", {18'd0, en3, en7, en9, en10, doneV, busyV, errV}, 32'd0);
    checkOutput("rstIter", iterCnt[0] | iterCnt[1], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic operations on the swap-enabled instance.
    applyStimulus(0, 32'd3, 32'd5, 1'b1);
    waitIdle(0, 60);
    checkOutput("r4_3x5", dpR4[0], 32'd15);
    applyStimulus(0, 32'd7, 32'd2, 1'b1);
    waitIdle(0, 60);
    checkOutput("r4_7x2", dpR4[0], 32'd14);
    applyStimulus(0, 32'd0, 32'd9, 1'b1);
    waitIdle(0, 60);
    checkOutput("r4_0x9", dpR4[0], 32'd0);

    // Watchdog trip on the limited instance, then error clears on restart.
    applyStimulus(1, 32'd10, 32'd1, 1'b1);
    waitIdle(1, 60);
    checkOutput("r4_watchdog", dpR4[1], 32'd4);
    checkOutput("errSticky", 32'(errV[1]), 32'd1);
    applyStimulus(1, 32'd2, 32'd3, 1'b1);
    waitIdle(1, 60);
    checkOutput("errAfterRestart", 32'(errV[1]), 32'd0);
    checkOutput("r4_2x3", dpR4[1], 32'd6);

    // A few random operand pairs.
    for (int i = 0; i < 3; i++) begin
      a = $urandom_range(0, 12);
      b = $urandom_range(0, 12);
      applyStimulus(0, a, b, 1'b1);
      waitIdle(0, 60);
      checkOutput("r4Rand", dpR4[0], a * b);
    end

    // Start held high across completion relaunches right after FINISH.
    @(posedge clk);
    #1;
    sbQ.push_back(model(0, 32'd2, 32'd3));
    sbQ.push_back(model(0, 32'd2, 32'd3));
    in1       = 32'd2;
    in2       = 32'd3;
    startV[0] = 1'b1;
    n         = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((sbQ.size() != 1) && (n < 60));
    checkOutput("firstOfHeld", 32'(sbQ.size()), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    startV[0] = 1'b0;
    waitIdle(0, 60);
    checkOutput("heldRelaunch", 32'(sbQ.size()), 32'd0);

    // Start pulsed while busy is ignored.
    applyStimulus(0, 32'd4, 32'd6, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    startV[0] = 1'b1;
    @(posedge clk);
    #1;
    startV[0] = 1'b0;
    waitIdle(0, 60);
    checkOutput("r4_4x6", dpR4[0], 32'd24);

    // Abort during the second Enable10 cycle.
    applyStimulus(0, 32'd5, 32'd6, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1;
    @(negedge clk);
    checkOutput("abortMasksEnables", {28'd0, en3[0], en7[0], en9[0], en10[0]}, 32'd0);
    checkOutput("abortNoDone", 32'(doneV[0]), 32'd0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    checkOutput("abortBusyFalls", 32'(busyV[0]), 32'd0);
    checkOutput("abortIter", iterCnt[0], 32'd1);
    repeat (8) @(negedge clk);
    checkOutput("abortNoCommit", dpR4[0], 32'd24);

    // Asynchronous reset in the middle of the loop.
    applyStimulus(0, 32'd9, 32'd9, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("preRstEn10", 32'(en10[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstOut", {18'd0, en3, en7, en9, en10, doneV, busyV, errV}, 32'd0);
    checkOutput("asyncRstIter", iterCnt[0], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("postRstIdle", {30'd0, busyV}, 32'd0);
    checkOutput("postRstNoEnable", {28'd0, en3[0], en7[0], en9[0], en10[0]}, 32'd0);
    checkOutput("sbDrained", 32'(sbQ.size()), 32'd0);

    $display("%0d/%0d checks passed", numPass, numChecks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL globalTimeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
